// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the bundle of per-cycle pipeline control strobes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_RUN      = 2'd0,
      PC_BUBBLE   = 2'd1,
      PC_FLUSH    = 2'd2,
      PC_WAIT_MDU = 2'd3
   } pc_state_e;

   typedef struct packed {
      logic pc_load;
      logic hold_pc;
      logic hold_if_id;
      logic flush_if_id;
      logic hold_id_ex;
      logic flush_id_ex;
   } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls of pipe_ctrl. The pipeline side
// uses the master modport, the sequencer itself uses the slave modport.
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             jump_en_i;
   logic [31:0]      jump_addr_i;
   logic             load_use_i;
   logic             mdu_start_i;
   logic             mdu_done_i;
   logic             imem_ready_i;
   logic             pc_load_o;
   logic [31:0]      pc_target_o;
   logic             hold_pc_o;
   logic             hold_if_id_o;
   logic             flush_if_id_o;
   logic             hold_id_ex_o;
   logic             flush_id_ex_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic             timeout_err_o;

   modport master (
      output jump_en_i, jump_addr_i, load_use_i, mdu_start_i, mdu_done_i, imem_ready_i,
      input  pc_load_o, pc_target_o, hold_pc_o, hold_if_id_o, flush_if_id_o,
             hold_id_ex_o, flush_id_ex_o, state_o, stall_cnt_o, timeout_err_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, load_use_i, mdu_start_i, mdu_done_i, imem_ready_i,
      output pc_load_o, pc_target_o, hold_pc_o, hold_if_id_o, flush_if_id_o,
             hold_id_ex_o, flush_id_ex_o, state_o, stall_cnt_o, timeout_err_o
   );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: increments while en_i is high and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard, redirect, MDU and
// fetch-wait events into hold/flush strobes for PC, if_id and id_ex.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MDU_TIMEOUT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic    clk,
   input  logic    rst,
   pipe_ctrl_if.slave bus
);
   pc_state_e   state_q, state_d;
   logic [3:0]  fcnt_q, fcnt_d;
   logic [15:0] timer_q, timer_d;
   logic        terr_q, terr_d;
   ctrl_t       ctrl;
   logic        take_jump;

   // EX is frozen while the MDU runs, so a jump seen then is stale and ignored.
   assign take_jump = bus.jump_en_i && (state_q != PC_WAIT_MDU);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      timer_d = timer_q;
      terr_d  = terr_q;
      ctrl    = '0;
      if (take_jump) begin
         ctrl.pc_load     = 1'b1;
         ctrl.flush_if_id = 1'b1;
         ctrl.flush_id_ex = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = PC_FLUSH;
            fcnt_d  = 4'(FLUSH_CYCLES - 1);
         end else begin
            state_d = PC_RUN;
         end
      end else begin
         case (state_q)
            PC_RUN: begin
               if (bus.mdu_start_i) begin
                  ctrl.hold_pc    = 1'b1;
                  ctrl.hold_if_id = 1'b1;
                  ctrl.hold_id_ex = 1'b1;
                  timer_d         = '0;
                  state_d         = PC_WAIT_MDU;
               end else if (bus.load_use_i) begin
                  ctrl.hold_pc     = 1'b1;
                  ctrl.hold_if_id  = 1'b1;
                  ctrl.flush_id_ex = 1'b1;
                  state_d          = PC_BUBBLE;
               end else if (!bus.imem_ready_i) begin
                  ctrl.hold_pc     = 1'b1;
                  ctrl.flush_if_id = 1'b1;
               end
            end
            // The bubble is already in id_ex; a still-asserted load_use must not add another.
            PC_BUBBLE: state_d = PC_RUN;
            PC_FLUSH: begin
               ctrl.flush_if_id = 1'b1;
               fcnt_d           = fcnt_q - 4'd1;
               if (fcnt_q == 4'd1) state_d = PC_RUN;
            end
            PC_WAIT_MDU: begin
               if (bus.mdu_done_i) begin
                  state_d = PC_RUN;
               end else begin
                  ctrl.hold_pc    = 1'b1;
                  ctrl.hold_if_id = 1'b1;
                  ctrl.hold_id_ex = 1'b1;
                  if (timer_q == 16'(MDU_TIMEOUT - 1)) begin
                     terr_d  = 1'b1;
                     state_d = PC_RUN;
                  end else begin
                     timer_d = timer_q + 16'd1;
                  end
               end
            end
            default: state_d = PC_RUN;
         endcase
      end
      // Reset must silence every strobe immediately, without waiting for an edge.
      if (!rst) ctrl = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PC_RUN;
         fcnt_q  <= '0;
         timer_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         timer_q <= timer_d;
         terr_q  <= terr_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (ctrl.hold_pc),
      .cnt_o (bus.stall_cnt_o)
   );

   assign bus.pc_load_o     = ctrl.pc_load;
   assign bus.pc_target_o   = ctrl.pc_load ? bus.jump_addr_i : 32'h0;
   assign bus.hold_pc_o     = ctrl.hold_pc;
   assign bus.hold_if_id_o  = ctrl.hold_if_id;
   assign bus.flush_if_id_o = ctrl.flush_if_id;
   assign bus.hold_id_ex_o  = ctrl.hold_id_ex;
   assign bus.flush_id_ex_o = ctrl.flush_id_ex;
   assign bus.state_o       = state_q;
   assign bus.timeout_err_o = terr_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked every cycle
// against a behavioural model through an expected-vector queue.
module tb_pipe_ctrl;
   localparam int CNT_W = 6;
   localparam int FC    = 3;
   localparam int TO    = 8;
   localparam int VW    = 41 + CNT_W;
   localparam int SMAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [VW-1:0] exp_q[$];

   // Model: pending work expressed as counts and flags rather than FSM states.
   bit m_in_mdu;
   int m_age;
   int m_flush_left;
   bit m_bubble;
   int m_stall;
   bit m_terr;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.FLUSH_CYCLES(FC), .MDU_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] act_vec();
      return {bus.pc_load_o, bus.pc_target_o, bus.hold_pc_o, bus.hold_if_id_o,
              bus.flush_if_id_o, bus.hold_id_ex_o, bus.flush_id_ex_o, bus.state_o,
              bus.stall_cnt_o, bus.timeout_err_o};
   endfunction

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_in_mdu = 0; m_age = 0; m_flush_left = 0; m_bubble = 0; m_stall = 0; m_terr = 0;
   endtask

   task automatic drive_idle();
      bus.jump_en_i = 0; bus.jump_addr_i = '0; bus.load_use_i = 0;
      bus.mdu_start_i = 0; bus.mdu_done_i = 0; bus.imem_ready_i = 1;
   endtask

   // Driver: one clock of stimulus; the expected response goes to the scoreboard.
   task automatic step(input bit j, input logic [31:0] a, input bit lu, input bit ms,
                       input bit md, input bit ir);
      bit pl, hp, hi, fi, he, fe;
      logic [1:0] st;
      @(posedge clk); #1;
      bus.jump_en_i = j; bus.jump_addr_i = a; bus.load_use_i = lu;
      bus.mdu_start_i = ms; bus.mdu_done_i = md; bus.imem_ready_i = ir;
      st = m_in_mdu ? 2'd3 : (m_flush_left > 0) ? 2'd2 : m_bubble ? 2'd1 : 2'd0;
      {pl, hp, hi, fi, he, fe} = '0;
      exp_q.push_back({1'b0, 32'h0, 5'b0, st, CNT_W'(m_stall), m_terr});
      if (m_in_mdu) begin
         if (md) m_in_mdu = 0;
         else begin
            {hp, hi, he} = 3'b111;
            if (m_age == TO - 1) begin m_terr = 1; m_in_mdu = 0; end
            else m_age++;
         end
      end else if (j) begin
         {pl, fi, fe} = 3'b111; m_flush_left = FC - 1; m_bubble = 0;
      end else if (m_flush_left > 0) begin
         fi = 1; m_flush_left--;
      end else if (m_bubble) begin
         m_bubble = 0;
      end else if (ms) begin
         {hp, hi, he} = 3'b111; m_in_mdu = 1; m_age = 0;
      end else if (lu) begin
         {hp, hi, fe} = 3'b111; m_bubble = 1;
      end else if (!ir) begin
         {hp, fi} = 2'b11;
      end
      exp_q[exp_q.size()-1][VW-1:VW-38] = {pl, pl ? a : 32'h0, hp, hi, fi, he, fe};
      if (hp && m_stall < SMAX) m_stall++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 0;
      drive_idle();
      exp_q.delete();
      #1 check("reset_outputs", act_vec(), '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      model_reset();
   endtask

   // Monitor: compares the DUT against the oldest expected vector, mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) check("cycle", act_vec(), exp_q.pop_front());
   end

   initial begin
      rst = 0;
      drive_idle();
      model_reset();
      #3 check("power_on_reset", act_vec(), '0);
      do_reset();

      // Load-use held for two cycles yields a single bubble.
      step(0, '0, 1, 0, 0, 1);
      step(0, '0, 1, 0, 0, 1);
      idle(2);

      // Jump with a 3-cycle if_id flush window.
      do_reset();
      step(1, 32'h80, 0, 0, 0, 1);
      idle(2);
      step(0, '0, 0, 0, 0, 1);
      check("jump_back_to_run", VW'({bus.state_o, bus.flush_if_id_o}), '0);

      // MDU completing five cycles after issue.
      do_reset();
      step(0, '0, 0, 1, 0, 1);
      idle(4);
      step(0, '0, 0, 0, 1, 1);
      step(0, '0, 0, 0, 0, 1);
      check("mdu_stall_cnt", VW'(bus.stall_cnt_o), VW'(5));

      // MDU with no done: forced exit and sticky error.
      do_reset();
      step(0, '0, 0, 1, 0, 1);
      idle(TO + 3);
      check("timeout_sticky", VW'({bus.state_o, bus.timeout_err_o}), VW'(1));

      // Simultaneous jump, load-use and MDU start: the jump wins.
      step(1, 32'h1234_5678, 1, 1, 0, 1);
      step(0, '0, 0, 0, 0, 1);
      check("jump_wins_state", VW'(bus.state_o), VW'(2));
      idle(3);

      // Asynchronous reset in the middle of an MDU wait.
      step(0, '0, 0, 1, 0, 1);
      idle(2);
      @(negedge clk); #2;
      rst = 0;
      #1 check("async_reset_mid_mdu", act_vec(), '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      model_reset();
      drive_idle();

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) != 0);
      end
      @(negedge clk); #1;
      check("queue_drained", VW'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
